// File: rtl/score_arbiter.sv
// score_arbiter
//   Round-robin arbiter that shares one score accumulator between NUM_LANES
//   lanes. A granted lane has combo-weighted points added to the score and
//   then receives a one-cycle acknowledge. A miss pulse from any lane clears
//   the combo.
//
//   Optional feature macro: SCORE_COMBO_MULT_EN
//     defined   : points = HIT_POINTS * min(1 + (combo >> 2), 4)
//     undefined : points = HIT_POINTS (combo still counted and cleared)
//
// Ports
//   clk    in   system clock
//   reset  in   asynchronous, active-low reset
//   req    in   [NUM_LANES] per-lane hit request, level, held until acked
//   miss   in   [NUM_LANES] per-lane miss pulse
//   ack    out  [NUM_LANES] one-hot, one-cycle acknowledge to the winner
//   score  out  [SCORE_W]   running score, saturating
//   combo  out  [8]         consecutive-hit count, saturating at 255
//   busy   out  high while in ADD or ACK
//
// Timing: when a lane launches req at edge t, the arbiter samples it at t+1
// (-> ADD), updates score/combo at t+2 (-> ACK, ack high t+2..t+3) and is
// back in IDLE at t+3. One hit every three cycles at most.
module score_arbiter #(
    parameter int NUM_LANES  = 4,
    parameter int SCORE_W    = 20,
    parameter int HIT_POINTS = 100
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_LANES-1:0] req,
    input  logic [NUM_LANES-1:0] miss,
    output logic [NUM_LANES-1:0] ack,
    output logic [SCORE_W-1:0]   score,
    output logic [7:0]           combo,
    output logic                 busy
);

    localparam int IDX_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int PTS_W = $clog2(HIT_POINTS * 4 + 1);
    localparam int SUM_W = ((SCORE_W > PTS_W) ? SCORE_W : PTS_W) + 1;

    typedef enum logic [1:0] {IDLE, ADD, ACK} state_t;

    state_t           state;
    logic [IDX_W-1:0] winner;
    logic [IDX_W-1:0] ptr;      // lane with highest priority on the next grant

    // Round-robin pick: first requester at or after ptr, wrapping.
    logic [IDX_W-1:0] sel;
    logic             found;
    int               idx;

    always_comb begin
        sel   = '0;
        found = 1'b0;
        idx   = 0;
        for (int off = 0; off < NUM_LANES; off++) begin
            idx = (int'(ptr) + off) % NUM_LANES;
            if (!found && req[IDX_W'(idx)]) begin
                sel   = IDX_W'(idx);
                found = 1'b1;
            end
        end
    end

    // Points for the current hit, always from the pre-increment combo.
    logic [PTS_W-1:0] points;

`ifdef SCORE_COMBO_MULT_EN
    logic [2:0] mult;

    always_comb begin
        // combo >= 12 already reaches the x4 ceiling; below that combo[7:4]
        // is zero, so combo[3:2] equals combo >> 2.
        if (combo[7:2] >= 6'd3) mult = 3'd4;
        else                    mult = 3'(combo[3:2]) + 3'd1;
        points = PTS_W'(HIT_POINTS) * PTS_W'(mult);
    end
`else
    always_comb begin
        points = PTS_W'(HIT_POINTS);
    end
`endif

    // Saturating score add: any carry above SCORE_W pins the score at max.
    logic [SUM_W-1:0]   sum;
    logic [SCORE_W-1:0] score_nxt;
    logic [7:0]         combo_inc;

    always_comb begin
        sum       = SUM_W'(score) + SUM_W'(points);
        score_nxt = (|sum[SUM_W-1:SCORE_W]) ? '1 : sum[SCORE_W-1:0];
        combo_inc = (combo == 8'hFF) ? combo : combo + 8'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            winner <= '0;
            ptr    <= '0;
            score  <= '0;
            combo  <= '0;
            ack    <= '0;
            busy   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        winner <= sel;
                        ptr    <= (sel == IDX_W'(NUM_LANES - 1)) ? '0 : sel + IDX_W'(1);
                        state  <= ADD;
                        busy   <= 1'b1;
                    end
                end
                ADD: begin
                    score <= score_nxt;
                    combo <= combo_inc;
                    ack   <= {{(NUM_LANES-1){1'b0}}, 1'b1} << winner;
                    state <= ACK;
                end
                ACK: begin
                    ack   <= '0;
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    ack   <= '0;
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
            // A miss overrides any combo update on the same edge.
            if (|miss) combo <= '0;
        end
    end

endmodule

// File: tb/tb_score_arbiter.sv
// Bench for score_arbiter: a transaction-level model checked every cycle,
// plus directed scenarios with hand-computed expectations. A second instance
// with SCORE_W=10 exercises score saturation.
module tb_score_arbiter;

    localparam int NL   = 4;
    localparam int HIT  = 100;
    localparam int SMAX = (1 << 20) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [NL-1:0] req, miss, ack;
    logic [19:0]   score;
    logic [7:0]    combo;
    logic          busy;

    logic          reset_s;
    logic [NL-1:0] req_s, miss_s, ack_s;
    logic [9:0]    score_s;
    logic [7:0]    combo_s;
    logic          busy_s;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    score_arbiter #(.NUM_LANES(NL), .SCORE_W(20), .HIT_POINTS(HIT)) dut (
        .clk(clk), .reset(reset), .req(req), .miss(miss),
        .ack(ack), .score(score), .combo(combo), .busy(busy)
    );

    score_arbiter #(.NUM_LANES(NL), .SCORE_W(10), .HIT_POINTS(HIT)) u_sat (
        .clk(clk), .reset(reset_s), .req(req_s), .miss(miss_s),
        .ack(ack_s), .score(score_s), .combo(combo_s), .busy(busy_s)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int mult_of(input int c);
`ifdef SCORE_COMBO_MULT_EN
        int m;
        m = 1 + (c >> 2);
        return (m > 4) ? 4 : m;
`else
        return 1;
`endif
    endfunction

    // ---------------- behavioural model ----------------
    // A grant is a three-cycle transaction: phase 1 = arbitration done,
    // phase 2 = points booked and ack shown, then back to idle.
    int            m_score = 0, m_combo = 0, m_ptr = 0, m_phase = 0, m_win = 0;
    logic [NL-1:0] m_ack = '0;

    task automatic model_step();
        int  pre;
        bit  got;
        if (!reset) begin
            m_score = 0; m_combo = 0; m_ptr = 0; m_phase = 0; m_win = 0; m_ack = '0;
        end else begin
            pre   = m_combo;
            m_ack = '0;
            if (m_phase == 0) begin
                if (req != '0) begin
                    got = 0;
                    for (int k = 0; k < NL; k++) begin
                        if (!got && req[(m_ptr + k) % NL]) begin
                            m_win = (m_ptr + k) % NL;
                            got   = 1;
                        end
                    end
                    m_ptr   = (m_win + 1) % NL;
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                m_score = m_score + HIT * mult_of(pre);
                if (m_score > SMAX) m_score = SMAX;
                m_combo = (pre >= 255) ? 255 : pre + 1;
                m_ack[m_win] = 1'b1;
                m_phase = 2;
            end else begin
                m_phase = 0;
            end
            if (miss != '0) m_combo = 0;
        end
    endtask

    initial forever begin
        @(posedge clk or negedge reset);
        model_step();
    end

    // ---------------- per-cycle compare ----------------
    int sat_hits = 0;
    int sat_prev = 0;
    int sat_tab[11];

    initial begin
`ifdef SCORE_COMBO_MULT_EN
        sat_tab = '{100, 200, 300, 400, 600, 800, 1000, 1023, 1023, 1023, 1023};
`else
        sat_tab = '{100, 200, 300, 400, 500, 600, 700, 800, 900, 1000, 1023};
`endif
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk("cyc_score", score, m_score);
            chk("cyc_combo", combo, m_combo);
            chk("cyc_ack",   ack,   m_ack);
            chk("cyc_busy",  busy,  m_phase != 0);
            chk("sat_nowrap", score_s >= sat_prev, 1);
            sat_prev = score_s;
            if (ack_s != '0) begin
                if (sat_hits < 11) chk("sat_step", score_s, sat_tab[sat_hits]);
                sat_hits++;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // Lanes drop their request on the cycle they see their ack.
    task automatic tick();
        @(negedge clk);
        req = req & ~ack;
    endtask

    task automatic wait_ack(output logic [NL-1:0] a, output int n);
        a = '0;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (ack != '0) begin
                a = ack;
                n = i;
                break;
            end
        end
        if (a == '0) begin
            tests++;
            fails++;
            $display("FAIL ack_timeout: got no ack, expected one within 20 cycles");
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        req = '0; miss = '0;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    // ---------------- directed scenarios ----------------
    logic [NL-1:0] a;
    int            n;

    initial begin
        reset = 1'b0; reset_s = 1'b0;
        req = '0; miss = '0; req_s = '0; miss_s = '0;
        repeat (2) @(negedge clk);
        chk("rst_score", score, 0);
        chk("rst_combo", combo, 0);
        chk("rst_ack",   ack,   0);
        chk("rst_busy",  busy,  0);
        reset = 1'b1; reset_s = 1'b1;

        // Single request from lane 2
        tick();
        req = 4'b0100;
        wait_ack(a, n);
        chk("t1_ack", a, 4'b0100);
        chk("t1_latency", n, 2);
        chk("t1_score", score, 100);
        chk("t1_combo", combo, 1);
        tick();
        chk("t1_ack_one_cycle", ack, 0);

        // Round robin with all lanes requesting
        do_reset();
        req = 4'b1111;
        for (int i = 0; i < NL; i++) begin
            wait_ack(a, n);
            chk("t2_order", a, 4'b0001 << i);
        end
        chk("t2_score4", score, 400);
        chk("t2_combo4", combo, 4);
        tick();
        req = 4'b0001;
        wait_ack(a, n);
        chk("t2_ack5", a, 4'b0001);
`ifdef SCORE_COMBO_MULT_EN
        chk("t2_score5", score, 600);
`else
        chk("t2_score5", score, 500);
`endif

        // Eight hits, miss, one more hit
        do_reset();
        for (int i = 0; i < 8; i++) begin
            req = 4'b0010;
            wait_ack(a, n);
        end
`ifdef SCORE_COMBO_MULT_EN
        chk("t3_score8", score, 1200);
`else
        chk("t3_score8", score, 800);
`endif
        chk("t3_combo8", combo, 8);
        tick();
        miss = 4'b1000;
        tick();
        miss = '0;
        chk("t3_combo_miss", combo, 0);
        req = 4'b0010;
        wait_ack(a, n);
`ifdef SCORE_COMBO_MULT_EN
        chk("t3_score9", score, 1300);
`else
        chk("t3_score9", score, 900);
`endif
        chk("t3_combo9", combo, 1);

        // Miss on the same edge as the score update
        do_reset();
        for (int i = 0; i < 5; i++) begin
            req = 4'b0001;
            wait_ack(a, n);
        end
        chk("t4_combo5", combo, 5);
        tick();
        req = 4'b0001;
        tick();                 // arbiter now in ADD
        miss = 4'b0001;
        tick();                 // update edge sees the miss
        miss = '0;
        chk("t4_ack", ack, 4'b0001);
`ifdef SCORE_COMBO_MULT_EN
        chk("t4_score", score, 800);
`else
        chk("t4_score", score, 600);
`endif
        chk("t4_combo", combo, 0);

        // Saturation on the 10-bit instance
        req_s = 4'b0001;
        for (int i = 0; i < 60 && sat_hits < 11; i++) tick();
        req_s = '0;
        chk("sat_hits", sat_hits >= 11, 1);
        chk("sat_final", score_s, 1023);
        repeat (4) tick();
        chk("sat_hold", score_s, 1023);

        // Reset in the middle of a transaction
        do_reset();
        req = 4'b0010;
        wait_ack(a, n);         // pointer now past lane 1
        tick();
        req = 4'b0100;
        tick();                 // arbiter now in ADD
        chk("t6_busy", busy, 1);
        #2 reset = 1'b0;
        #1;
        chk("t6_score", score, 0);
        chk("t6_combo", combo, 0);
        chk("t6_ack",   ack,   0);
        req = '0;
        tick();
        chk("t6_no_ack", ack, 0);
        reset = 1'b1;
        req = 4'b1111;
        wait_ack(a, n);
        chk("t6_first_lane0", a, 4'b0001);
        req = '0;
        repeat (4) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
